// File: rtl/mem_io_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_io_responder
//  Brief    : Data-memory bus responder with word RAM, LED register, cycle
//             counter and synchronized switches; one-cycle registered reads.
//             Optional macro ADDR_ERR_EN enables the sticky err flag.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_io_responder #(
    parameter int DEPTH_LOG2 = 7,
    parameter int CNT_W      = 16,
    parameter int SW_W       = 9
) (
    input  logic            Clock,
    input  logic            Resetn,
    input  logic [15:0]     addr,
    input  logic [15:0]     dout,
    input  logic            w,
    input  logic [SW_W-1:0] SW,
    output logic [15:0]     DATA,
    output logic [SW_W-1:0] LEDR,
    output logic            err
);

    localparam logic [3:0] c_REG_RAM = 4'h0;
    localparam logic [3:0] c_REG_LED = 4'h1;
    localparam logic [3:0] c_REG_CNT = 4'h2;
    localparam logic [3:0] c_REG_SW  = 4'h3;

    logic [3:0]            w_region;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [15:0]           mem [2**DEPTH_LOG2];

    logic [15:0]     data_d, data_q;
    logic [SW_W-1:0] led_d, led_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [SW_W-1:0] sw_sync1_q, sw_sync2_q;

    assign w_region = addr[15:12];
    assign w_idx    = addr[DEPTH_LOG2-1:0];

    // RAM is not reset; writes are held off while Resetn is low.
    always_ff @(posedge Clock) begin
        if (Resetn && w && (w_region == c_REG_RAM)) begin
            mem[w_idx] <= dout;
        end
    end

    always_comb begin
        data_d = 16'h0000;
        case (w_region)
            c_REG_RAM: data_d = mem[w_idx];
            c_REG_LED: data_d = 16'(led_q);
            c_REG_CNT: data_d = 16'(cnt_q);
            c_REG_SW:  data_d = 16'(sw_sync2_q);
            default:   data_d = 16'h0000;
        endcase
    end

    always_comb begin
        led_d = led_q;
        cnt_d = cnt_q + CNT_W'(1);
        if (w && (w_region == c_REG_LED)) begin
            led_d = dout[SW_W-1:0];
        end
        if (w && (w_region == c_REG_CNT)) begin
            cnt_d = CNT_W'(dout);
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            data_q     <= '0;
            led_q      <= '0;
            cnt_q      <= '0;
            sw_sync1_q <= '0;
            sw_sync2_q <= '0;
        end else begin
            data_q     <= data_d;
            led_q      <= led_d;
            cnt_q      <= cnt_d;
            sw_sync1_q <= SW;
            sw_sync2_q <= sw_sync1_q;
        end
    end

    assign DATA = data_q;
    assign LEDR = led_q;

`ifdef ADDR_ERR_EN
    logic err_d, err_q;
    logic w_bad_addr;

    // Alias writes to RAM still land at the folded index but are flagged.
    assign w_bad_addr = (w_region == c_REG_SW) || (w_region > c_REG_SW) ||
                        ((w_region == c_REG_RAM) && (addr[11:DEPTH_LOG2] != '0));

    always_comb begin
        err_d = err_q | (w & w_bad_addr);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic w_unused_alias;
    assign w_unused_alias = ^addr[11:DEPTH_LOG2];
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_io_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_io_responder
//  Brief    : Scoreboard bench for mem_io_responder with a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_io_responder;

    localparam int c_DEPTH = 128;

    logic        clk;
    logic        rst_n;
    logic [15:0] addr;
    logic [15:0] dout;
    logic        w;
    logic [8:0]  sw;
    logic [15:0] data;
    logic [8:0]  ledr;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_io_responder #(.DEPTH_LOG2(7), .CNT_W(16), .SW_W(9)) dut (
        .Clock (clk),
        .Resetn(rst_n),
        .addr  (addr),
        .dout  (dout),
        .w     (w),
        .SW    (sw),
        .DATA  (data),
        .LEDR  (ledr),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        bit          chk_data;
        logic [8:0]  led;
        logic        err;
    } exp_t;

    exp_t q[$];

    // Reference state
    logic [15:0] m_mem [c_DEPTH];
    bit          m_valid [c_DEPTH];
    logic [8:0]  m_led;
    logic [15:0] m_cnt;
    logic [8:0]  m_sw_h1, m_sw_h2;
    logic        m_err;

    initial begin
        for (int i = 0; i < c_DEPTH; i++) m_valid[i] = 1'b0;
        m_led = '0; m_cnt = '0; m_sw_h1 = '0; m_sw_h2 = '0; m_err = 1'b0;
    end

    task automatic model_reset();
        m_led = '0; m_cnt = '0; m_sw_h1 = '0; m_sw_h2 = '0; m_err = 1'b0;
    endtask

    always @(negedge rst_n) begin
        model_reset();
        q.delete();
    end

    always @(posedge clk) begin
        exp_t e;
        int   idx;
        int   region;
        e.data = 16'h0; e.chk_data = 1'b1;
        if (!rst_n) begin
            model_reset();
        end else begin
            region = int'(addr[15:12]);
            idx    = int'(addr[6:0]);
            if (region == 0) begin
                e.data = m_mem[idx];
                e.chk_data = m_valid[idx];
            end else if (region == 1) e.data = {7'h0, m_led};
            else if (region == 2)     e.data = m_cnt;
            else if (region == 3)     e.data = {7'h0, m_sw_h2};
            else                      e.data = 16'h0;
            m_cnt = m_cnt + 16'd1;
            if (w) begin
                if (region == 0) begin
                    m_mem[idx] = dout;
                    m_valid[idx] = 1'b1;
                end else if (region == 1) m_led = dout[8:0];
                else if (region == 2)     m_cnt = dout;
`ifdef ADDR_ERR_EN
                if (region >= 3 || (region == 0 && addr[11:7] != 5'd0)) m_err = 1'b1;
`endif
            end
            m_sw_h2 = m_sw_h1;
            m_sw_h1 = sw;
        end
        e.led = m_led;
        e.err = m_err;
        q.push_back(e);
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: DATA is presented every cycle, so pop once per edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.chk_data) check("DATA", data, e.data);
            check("LEDR", {7'h0, ledr}, {7'h0, e.led});
            check("err", {15'h0, err}, {15'h0, e.err});
        end
    end

    task automatic cyc(input logic [15:0] a, input logic [15:0] d, input logic wr);
        addr = a; dout = d; w = wr;
        @(negedge clk);
    endtask

    task automatic async_reset(input int hold);
        rst_n = 1'b0;
        #1;
        check("async DATA", data, 16'h0);
        check("async LEDR", {7'h0, ledr}, 16'h0);
        check("async err", {15'h0, err}, 16'h0);
        w = 1'b0;
        repeat (hold) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; addr = 16'h2000; dout = '0; w = 1'b0; sw = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) cyc(16'h2000, 16'h0, 1'b0);

        cyc(16'h0005, 16'hBEEF, 1'b1);
        cyc(16'h0005, 16'h0, 1'b0);
        cyc(16'h0005, 16'h1234, 1'b1);
        cyc(16'h0005, 16'h0, 1'b0);

        cyc(16'h1000, 16'h01A5, 1'b1);
        cyc(16'h1000, 16'h0, 1'b0);
        cyc(16'h3000, 16'hFFFF, 1'b1);
        cyc(16'h1000, 16'h0, 1'b0);
        cyc(16'h0005, 16'h0, 1'b0);

        cyc(16'h2000, 16'hFFFE, 1'b1);
        repeat (4) cyc(16'h2000, 16'h0, 1'b0);

        sw = 9'h155;
        repeat (4) cyc(16'h3000, 16'h0, 1'b0);
        sw = 9'h0AA;
        cyc(16'h3000, 16'h0, 1'b0);
        async_reset(2);
        repeat (4) cyc(16'h3000, 16'h0, 1'b0);

        cyc(16'h0085, 16'hCAFE, 1'b1);
        cyc(16'h0005, 16'h0, 1'b0);
        cyc(16'h1000, 16'h0033, 1'b1);
        cyc(16'h1000, 16'h0, 1'b0);
        async_reset(1);
        cyc(16'h0005, 16'h0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            logic [15:0] a;
            logic [15:0] d;
            int sel;
            sel = int'($urandom_range(0, 9));
            d = 16'($urandom);
            case (sel)
                0, 1, 2: a = {9'h0, 7'($urandom_range(0, 15))};
                3:       a = {4'h0, 12'($urandom)};
                4:       a = {4'h1, 12'($urandom)};
                5, 6: begin
                    a = {4'h2, 12'($urandom)};
                    if ($urandom_range(0, 1) == 0) d = 16'hFFF0 | 16'($urandom_range(0, 15));
                end
                7:       a = {4'h3, 12'($urandom)};
                default: a = {4'($urandom_range(4, 15)), 12'($urandom)};
            endcase
            if ($urandom_range(0, 7) == 0) sw = 9'($urandom);
            cyc(a, d, ($urandom_range(0, 2) == 0));
            if (i == 1500) async_reset(2);
        end

        repeat (2) cyc(16'h2000, 16'h0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
